axi_rd_responder: RTL and testbench

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

---
 rtl/axi_rd_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_responder
// Purpose  : AXI read slave model. Queues incoming read-address requests and
//            answers each with ar_len+1 data beats whose payload is the beat
//            address. Requests are served oldest-first (ooo_en=0) or
//            newest-first (ooo_en=1) so out-of-order returns can be forced.
// Ports    : clk        - single clock, rising edge
//            rst        - synchronous active-low reset
//            ar_*       - AXI read-address channel (slave side)
//            r_*        - AXI read-data channel (slave side)
//            ooo_en     - 0: FIFO service order, 1: LIFO service order
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH      = 4,
  parameter int MAX_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // read-address channel
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [LEN_WIDTH-1:0]  ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  // read-data channel
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [RESP_WIDTH-1:0] r_resp,
  output logic                  r_last,
  // service order select
  input  logic                  ooo_en
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2;

  localparam logic [CNT_W-1:0]      C_DEPTH       = CNT_W'(DEPTH);
  localparam logic [LEN_WIDTH:0]    C_MAX_LEN     = (LEN_WIDTH + 1)'(MAX_LEN);
  localparam logic [1:0]            C_BURST_INCR  = 2'b01;
  localparam logic [1:0]            C_BURST_RSVD  = 2'b11;
  localparam logic [RESP_WIDTH-1:0] C_RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] C_RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ENTRY_W-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // registers of the burst currently being returned
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;

  // --------------------------------------------------------------------------
  // Pop-side entry selection
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]      wr_ptr_m1;
  logic [ENTRY_W-1:0]    pop_entry;
  logic [ID_WIDTH-1:0]   pop_id;
  logic [ADDR_WIDTH-1:0] pop_addr;
  logic [LEN_WIDTH-1:0]  pop_len;
  logic [2:0]            pop_size;
  logic [1:0]            pop_burst;
  logic                  pop_err;

  logic                  do_push;
  logic                  do_pop;

  assign wr_ptr_m1 = wr_ptr_q - PTR_W'(1);
  assign pop_entry = ooo_en ? mem_q[wr_ptr_m1] : mem_q[rd_ptr_q];
  assign {pop_id, pop_addr, pop_len, pop_size, pop_burst} = pop_entry;

  // Error is decided once per burst; the full beat count is still returned.
  assign pop_err = (pop_burst == C_BURST_RSVD) ||
                   (({1'b0, pop_len} + (LEN_WIDTH + 1)'(1)) > C_MAX_LEN);

  // A LIFO pop moves wr_ptr backwards, so a push in the same cycle would
  // collide on the write pointer; the address channel is closed instead.
  assign ar_ready = (count_q < C_DEPTH) &&
                    !((state_q == IDLE) && (count_q != '0) && ooo_en);

  assign do_push = ar_valid && ar_ready;
  assign do_pop  = (state_q == IDLE) && (count_q != '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    beat_d   = beat_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = {ar_id, ar_addr, ar_len, ar_size, ar_burst};
    end

    case (state_q)
      IDLE: begin
        if (do_pop) begin
          id_d    = pop_id;
          addr_d  = pop_addr;
          len_d   = pop_len;
          size_d  = pop_size;
          burst_d = pop_burst;
          err_d   = pop_err;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (r_ready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pointer bookkeeping: FIFO pops advance rd_ptr, LIFO pops retreat wr_ptr.
    if (do_pop && ooo_en) begin
      wr_ptr_d = wr_ptr_m1;
    end else if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop && !ooo_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
    end
  end

  // Queue storage carries no reset: an entry is only read while count says
  // it is valid, and reset clears count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // --------------------------------------------------------------------------
  // Read-data outputs (all zero while no beat is offered)
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] beat_offs;
  logic [ADDR_WIDTH-1:0] beat_addr;

  assign beat_offs = ADDR_WIDTH'(beat_q) << size_q;
  // Only INCR advances; FIXED, WRAP and the reserved encoding repeat ar_addr.
  assign beat_addr = (burst_q == C_BURST_INCR) ? (addr_q + beat_offs) : addr_q;

  assign r_valid = (state_q == BURST);
  assign r_id    = r_valid ? id_q : '0;
  assign r_data  = r_valid ? DATA_WIDTH'(beat_addr) : '0;
  assign r_resp  = r_valid ? (err_q ? C_RESP_SLVERR : C_RESP_OKAY) : '0;
  assign r_last  = r_valid && (beat_q == len_q);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_responder
// Purpose  : Directed self-checking bench for axi_rd_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_responder;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int RESP_W  = 2;
  localparam int LEN_W   = 8;
  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 8;
  localparam int BW      = ID_W + DATA_W + RESP_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ar_valid = 1'b0;
  logic              ar_ready;
  logic [ID_W-1:0]   ar_id = '0;
  logic [ADDR_W-1:0] ar_addr = '0;
  logic [LEN_W-1:0]  ar_len = '0;
  logic [2:0]        ar_size = '0;
  logic [1:0]        ar_burst = '0;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [RESP_W-1:0] r_resp;
  logic              r_last;
  logic              ooo_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_rd_responder #(
    .ID_WIDTH  (ID_W),
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .RESP_WIDTH(RESP_W),
    .LEN_WIDTH (LEN_W),
    .DEPTH     (DEPTH),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ar_valid(ar_valid),
    .ar_ready(ar_ready),
    .ar_id   (ar_id),
    .ar_addr (ar_addr),
    .ar_len  (ar_len),
    .ar_size (ar_size),
    .ar_burst(ar_burst),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_id    (r_id),
    .r_data  (r_data),
    .r_resp  (r_resp),
    .r_last  (r_last),
    .ooo_en  (ooo_en)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    ooo_en   = 1'b0;
    repeat (5) step();
    rst = 1'b1;
  endtask

  // Present one AR and hold it until accepted (bounded).
  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [LEN_W-1:0] len, input logic [2:0] size,
                         input logic [1:0] burst, output bit acc);
    int n;
    acc      = 1'b0;
    n        = 0;
    ar_valid = 1'b1;
    ar_id    = id;
    ar_addr  = addr;
    ar_len   = len;
    ar_size  = size;
    ar_burst = burst;
    while (!acc && n < 20) begin
      if (ar_ready === 1'b1) acc = 1'b1;
      step();
      n++;
    end
    ar_valid = 1'b0;
  endtask

  // Accept one R beat with r_ready=1; waited = idle cycles before it appeared.
  task automatic recv_beat(output bit ok, output int waited, output logic [BW-1:0] beat);
    ok      = 1'b0;
    waited  = 0;
    beat    = '0;
    r_ready = 1'b1;
    while (r_valid !== 1'b1 && waited < 30) begin
      step();
      waited++;
    end
    if (r_valid === 1'b1) begin
      ok   = 1'b1;
      beat = {r_id, r_data, r_resp, r_last};
      step();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    repeat (5) step();
    n_tests++;
    if ({r_valid, r_id, r_data, r_resp, r_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {r_valid, r_id, r_data, r_resp, r_last});
    end
    rst = 1'b1;
    n_tests++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ar_ready: got %b expected 1", ar_ready);
    end
    step();
    n_tests++;
    if ({ar_ready, r_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_idle: got ar_ready,r_valid=%b expected 10", {ar_ready, r_valid});
    end
    r_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    r_ready  = 1'b1;
    ar_valid = 1'b1;
    ar_id    = 4'd0;
    ar_addr  = 32'h1000;
    ar_len   = 8'd0;
    ar_size  = 3'd3;
    ar_burst = 2'b01;
    n_tests++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ar_ready: got %b expected 1", ar_ready);
    end
    step();
    ar_valid = 1'b0;
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: r_valid got %b expected 0", r_valid);
    end
    step();
    n_tests++;
    if ({r_valid, r_id, r_data, r_resp, r_last} !== {1'b1, 4'd0, 64'h1000, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL single_beat: got %h expected %h", {r_valid, r_id, r_data, r_resp, r_last},
               {1'b1, 4'd0, 64'h1000, 2'b00, 1'b1});
    end
    step();
    n_tests++;
    if ({r_valid, r_data} !== '0) begin
      n_fail++;
      $display("FAIL single_after: got %h expected 0", {r_valid, r_data});
    end
  endtask

  task automatic test_backpressure();
    bit              acc;
    int              waited;
    logic [BW:0]     exp;
    do_reset();
    send_ar(4'd5, 32'h4000, 8'd3, 3'd3, 2'b01, acc);
    waited = 0;
    while (r_valid !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    n_tests++;
    if (!acc || waited != 1) begin
      n_fail++;
      $display("FAIL bp_latency: got acc=%0d waited=%0d expected acc=1 waited=1", acc, waited);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 4'd5, 64'h4000 + 64'(i * 8), 2'b00, (i == 3)};
      n_tests++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== exp) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h expected %h", i, {r_valid, r_id, r_data, r_resp, r_last}, exp);
      end
      step();
      n_tests++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== exp) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got %h expected %h", i, {r_valid, r_id, r_data, r_resp, r_last}, exp);
      end
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
    end
    n_tests++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: r_valid got %b expected 0", r_valid);
    end
  endtask

  task automatic test_order(input bit lifo);
    bit              a0, a1, a2, ok;
    int              waited;
    logic [BW-1:0]   beat;
    logic [ADDR_W-1:0] ord [3];
    do_reset();
    ooo_en = lifo;
    ord[0] = 32'h2000;
    ord[1] = lifo ? 32'h5000 : 32'h3000;
    ord[2] = lifo ? 32'h3000 : 32'h5000;
    send_ar(4'd3, 32'h2000, 8'd0, 3'd3, 2'b01, a0);
    send_ar(4'd3, 32'h3000, 8'd0, 3'd3, 2'b01, a1);
    send_ar(4'd3, 32'h5000, 8'd0, 3'd3, 2'b01, a2);
    n_tests++;
    if ({a0, a1, a2, r_valid, r_data} !== {4'b1111, 64'h2000}) begin
      n_fail++;
      $display("FAIL order%0d_first: got acc=%b%b%b r_valid=%b r_data=%h expected 111 1 2000",
               lifo, a0, a1, a2, r_valid, r_data);
    end
    for (int i = 0; i < 3; i++) begin
      recv_beat(ok, waited, beat);
      n_tests++;
      if (!ok || beat !== {4'd3, DATA_W'(ord[i]), 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL order%0d_beat%0d: got ok=%0d %h expected %h", lifo, i, ok, beat,
                 {4'd3, DATA_W'(ord[i]), 2'b00, 1'b1});
      end
      n_tests++;
      if (waited != ((i == 0) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL order%0d_gap%0d: got %0d idle cycles expected %0d", lifo, i, waited,
                 (i == 0) ? 0 : 1);
      end
    end
    ooo_en = 1'b0;
  endtask

  task automatic test_full();
    bit            acc, ok;
    bit [4:0]      accs;
    int            waited;
    logic [BW-1:0] beat;
    logic [BW-1:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_ar(ID_W'(k), ADDR_W'((k + 1) * 32'h100), 8'd0, 3'd3, 2'b01, acc);
      accs[k] = acc;
    end
    n_tests++;
    if ({accs, ar_ready} !== 6'b111110) begin
      n_fail++;
      $display("FAIL full_fill: got accepts=%b ar_ready=%b expected 11111 0", accs, ar_ready);
    end
    ar_valid = 1'b1;
    ar_id    = 4'd6;
    ar_addr  = 32'h600;
    ar_len   = 8'd0;
    ar_size  = 3'd3;
    ar_burst = 2'b01;
    step();
    n_tests++;
    if (ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_blocked: ar_ready got %b expected 0", ar_ready);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    n_tests++;
    if ({ar_ready, r_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_idle: ar_ready,r_valid got %b expected 00", {ar_ready, r_valid});
    end
    step();
    n_tests++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reopen: ar_ready got %b expected 1", ar_ready);
    end
    step();
    ar_valid = 1'b0;
    n_tests++;
    if (ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refill: ar_ready got %b expected 0", ar_ready);
    end
    for (int k = 1; k < 6; k++) begin
      exp = (k == 5) ? {4'd6, 64'h600, 2'b00, 1'b1}
                     : {ID_W'(k), DATA_W'((k + 1) * 32'h100), 2'b00, 1'b1};
      recv_beat(ok, waited, beat);
      n_tests++;
      if (!ok || beat !== exp) begin
        n_fail++;
        $display("FAIL full_drain%0d: got ok=%0d %h expected %h", k, ok, beat, exp);
      end
    end
  endtask

  task automatic test_errors();
    int            t_id     [5] = '{1, 2, 4, 7, 8};
    int            t_addr   [5] = '{32'h40, 32'h80, 32'h0, 32'h10, 32'h300};
    int            t_len    [5] = '{1, 2, 8, 7, 1};
    int            t_size   [5] = '{3, 3, 2, 2, 3};
    int            t_burst  [5] = '{3, 0, 1, 1, 2};
    int            t_stride [5] = '{0, 0, 4, 4, 0};
    int            t_resp   [5] = '{2, 0, 2, 0, 0};
    bit            acc, ok;
    int            waited;
    logic [BW-1:0] beat;
    logic [BW-1:0] exp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      send_ar(ID_W'(t_id[c]), ADDR_W'(t_addr[c]), LEN_W'(t_len[c]), 3'(t_size[c]),
              2'(t_burst[c]), acc);
      n_tests++;
      if (!acc) begin
        n_fail++;
        $display("FAIL err_accept case=%0d: got 0 expected 1", c);
      end
      for (int b = 0; b <= t_len[c]; b++) begin
        exp = {ID_W'(t_id[c]), DATA_W'(t_addr[c] + b * t_stride[c]), RESP_W'(t_resp[c]),
               (b == t_len[c])};
        recv_beat(ok, waited, beat);
        n_tests++;
        if (!ok || beat !== exp) begin
          n_fail++;
          $display("FAIL err_beat case=%0d beat=%0d: got ok=%0d %h expected %h", c, b, ok, beat, exp);
        end
      end
      n_tests++;
      if (r_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err_extra case=%0d: r_valid got %b expected 0", c, r_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit a0, a1;
    bit seen;
    do_reset();
    send_ar(4'd9, 32'h700, 8'd3, 3'd3, 2'b01, a0);
    send_ar(4'd10, 32'h800, 8'd0, 3'd3, 2'b01, a1);
    n_tests++;
    if ({a0, a1, r_valid} !== 3'b111) begin
      n_fail++;
      $display("FAIL rstmid_setup: got %b expected 111", {a0, a1, r_valid});
    end
    rst = 1'b0;
    step();
    rst     = 1'b1;
    r_ready = 1'b1;
    n_tests++;
    if ({r_valid, ar_ready, r_data} !== {2'b01, 64'h0}) begin
      n_fail++;
      $display("FAIL rstmid_clear: got r_valid=%b ar_ready=%b r_data=%h expected 0 1 0",
               r_valid, ar_ready, r_data);
    end
    seen = 1'b0;
    repeat (6) begin
      step();
      if (r_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nobeats: got beats after reset=%b expected 0", seen);
    end
    r_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_order(1'b1);
    test_order(1'b0);
    test_full();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
